// File: rtl/sh7604_ibus_master.sv
// SH7604 internal peripheral bus initiator: DMAC/CPU arbitration, one IBUS transaction at a time,
// big-endian lane generation, wait-state handling and error reporting.
module sh7604_ibus_master #(
  parameter int WAIT_MAX = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic        EN,
  input  logic [31:0] CPU_A,
  input  logic [31:0] CPU_DI,
  input  logic [1:0]  CPU_SZ,
  input  logic        CPU_WE,
  input  logic        CPU_REQ,
  output logic [31:0] CPU_DO,
  output logic        CPU_ACK,
  output logic        CPU_ERR,
  input  logic [31:0] DMA_A,
  input  logic [31:0] DMA_DI,
  input  logic [1:0]  DMA_SZ,
  input  logic        DMA_WE,
  input  logic        DMA_REQ,
  output logic [31:0] DMA_DO,
  output logic        DMA_ACK,
  output logic        DMA_ERR,
  output logic [31:0] IBUS_A,
  output logic [31:0] IBUS_DO,
  input  logic [31:0] IBUS_DI,
  output logic [3:0]  IBUS_BA,
  output logic        IBUS_WE,
  output logic        IBUS_REQ,
  input  logic        IBUS_BUSY,
  input  logic        IBUS_ACT
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  localparam logic [7:0] LP_WAIT_MAX = 8'(WAIT_MAX);

  state_t      r_state;
  logic        r_gnt_dma;
  logic [1:0]  r_a_lo;
  logic [1:0]  r_sz;
  logic        r_we;
  logic [7:0]  r_cnt;
  logic [31:0] r_ibus_a, r_ibus_do, r_cpu_do, r_dma_do;
  logic [3:0]  r_ibus_ba;
  logic        r_ibus_we, r_ibus_req;
  logic        r_cpu_ack, r_cpu_err, r_dma_ack, r_dma_err;

  logic        w_req;
  logic [31:0] w_a, w_di;
  logic [1:0]  w_sz;
  logic        w_we, w_misalign, w_bus_ok, w_bus_fin;
  logic [3:0]  w_ba;
  logic [31:0] w_wd, w_rd;
  logic [7:0]  w_cnt_inc;
  logic        w_unused;

  assign w_unused  = CE_F;
  assign w_req     = DMA_REQ | CPU_REQ;
  assign w_a       = DMA_REQ ? DMA_A  : CPU_A;
  assign w_di      = DMA_REQ ? DMA_DI : CPU_DI;
  assign w_sz      = DMA_REQ ? DMA_SZ : CPU_SZ;
  assign w_we      = DMA_REQ ? DMA_WE : CPU_WE;
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_bus_ok  = IBUS_ACT & ~IBUS_BUSY;
  // ACT has precedence: a missing slave ends the cycle whatever BUSY says
  assign w_bus_fin = ~IBUS_ACT | ~IBUS_BUSY | (w_cnt_inc == LP_WAIT_MAX);

  // Size 3 (reserved) falls into the long branches
  always_comb begin
    w_misalign = 1'b0;
    w_ba       = 4'b1111;
    w_wd       = w_di;
    case (w_sz)
      2'd0: begin
        w_ba = 4'b1000 >> w_a[1:0];
        w_wd = {4{w_di[7:0]}};
      end
      2'd1: begin
        w_misalign = w_a[0];
        w_ba       = w_a[1] ? 4'b0011 : 4'b1100;
        w_wd       = {2{w_di[15:0]}};
      end
      default: w_misalign = (w_a[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    w_rd = IBUS_DI;
    case (r_sz)
      2'd0: begin
        case (r_a_lo)
          2'd0:    w_rd = {24'd0, IBUS_DI[31:24]};
          2'd1:    w_rd = {24'd0, IBUS_DI[23:16]};
          2'd2:    w_rd = {24'd0, IBUS_DI[15:8]};
          default: w_rd = {24'd0, IBUS_DI[7:0]};
        endcase
      end
      2'd1:    w_rd = r_a_lo[1] ? {16'd0, IBUS_DI[15:0]} : {16'd0, IBUS_DI[31:16]};
      default: w_rd = IBUS_DI;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_gnt_dma  <= 1'b0;
      r_a_lo     <= 2'd0;
      r_sz       <= 2'd0;
      r_we       <= 1'b0;
      r_cnt      <= 8'd0;
      r_ibus_a   <= 32'd0;
      r_ibus_do  <= 32'd0;
      r_ibus_ba  <= 4'd0;
      r_ibus_we  <= 1'b0;
      r_ibus_req <= 1'b0;
      r_cpu_do   <= 32'd0;
      r_dma_do   <= 32'd0;
      r_cpu_ack  <= 1'b0;
      r_cpu_err  <= 1'b0;
      r_dma_ack  <= 1'b0;
      r_dma_err  <= 1'b0;
    end else if (EN && CE_R) begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_gnt_dma <= DMA_REQ;
            r_a_lo    <= w_a[1:0];
            r_sz      <= w_sz;
            r_we      <= w_we;
            if (w_misalign) begin
              r_state   <= S_DONE;
              r_cpu_ack <= ~DMA_REQ;
              r_cpu_err <= ~DMA_REQ;
              r_dma_ack <= DMA_REQ;
              r_dma_err <= DMA_REQ;
              if (DMA_REQ) r_dma_do <= 32'd0;
              else         r_cpu_do <= 32'd0;
            end else begin
              r_state    <= S_BUS;
              r_cnt      <= 8'd0;
              r_ibus_a   <= {w_a[31:2], 2'b00};
              r_ibus_ba  <= w_ba;
              r_ibus_do  <= w_wd;
              r_ibus_we  <= w_we;
              r_ibus_req <= 1'b1;
            end
          end
        end
        S_BUS: begin
          if (IBUS_ACT && IBUS_BUSY) r_cnt <= w_cnt_inc;
          if (w_bus_fin) begin
            r_state    <= S_DONE;
            r_ibus_req <= 1'b0;
            r_cpu_ack  <= ~r_gnt_dma;
            r_cpu_err  <= ~r_gnt_dma & ~w_bus_ok;
            r_dma_ack  <= r_gnt_dma;
            r_dma_err  <= r_gnt_dma & ~w_bus_ok;
            // successful writes leave the client's read data untouched
            if (!w_bus_ok || !r_we) begin
              if (r_gnt_dma) r_dma_do <= w_bus_ok ? w_rd : 32'd0;
              else           r_cpu_do <= w_bus_ok ? w_rd : 32'd0;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_cpu_ack <= 1'b0;
          r_cpu_err <= 1'b0;
          r_dma_ack <= 1'b0;
          r_dma_err <= 1'b0;
        end
      endcase
    end
  end

  assign IBUS_A   = r_ibus_a;
  assign IBUS_DO  = r_ibus_do;
  assign IBUS_BA  = r_ibus_ba;
  assign IBUS_WE  = r_ibus_we;
  assign IBUS_REQ = r_ibus_req;
  assign CPU_DO   = r_cpu_do;
  assign CPU_ACK  = r_cpu_ack;
  assign CPU_ERR  = r_cpu_err;
  assign DMA_DO   = r_dma_do;
  assign DMA_ACK  = r_dma_ack;
  assign DMA_ERR  = r_dma_err;

endmodule

// File: doc/sh7604_ibus_master.md
Name: sh7604_ibus_master

Overview:
- Initiator side of the SH7604 internal peripheral bus (IBUS). It arbitrates two clients, CPU data port and DMAC, and issues one IBUS transaction at a time to the on-chip register slaves (UBC, DMAC, FRT, WDT, SCI, ...).
- It generates big-endian byte lanes and replicated write data, honours slave wait states, and returns lane-extracted read data.
- Missing-slave, timeout and misalignment cases are reported as errors.

Parameters:
- WAIT_MAX, 255: maximum consecutive BUSY CE_R samples before timeout error; counter is 8 bits.

Ports:
- CLK  in  1  clock
- RST_N  in  1  async active-low reset
- CE_R  in  1  rising-phase clock enable; all state advances here
- CE_F  in  1  falling-phase enable; unused internally, passed for bench alignment
- EN  in  1  global enable; when 0, all state freezes
- CPU_A / DMA_A  in  32  client address
- CPU_DI / DMA_DI  in  32  client write data, right-justified
- CPU_SZ / DMA_SZ  in  2  access size: 0=byte, 1=word, 2=long, 3=reserved (treated as long)
- CPU_WE / DMA_WE  in  1  write
- CPU_REQ / DMA_REQ  in  1  request; held until the matching ACK
- CPU_DO / DMA_DO  out  32  read data, zero-extended, right-justified
- CPU_ACK / DMA_ACK  out  1  completion, high during DONE
- CPU_ERR / DMA_ERR  out  1  error qualifier, valid with ACK
- IBUS_A  out  32  bus address
- IBUS_DO  out  32  bus write data (to slave DI)
- IBUS_DI  in  32  OR-combined slave read data
- IBUS_BA  out  4  byte lanes; bit3 = bits 31:24
- IBUS_WE  out  1  write
- IBUS_REQ  out  1  request
- IBUS_BUSY  in  1  OR of slave BUSY
- IBUS_ACT  in  1  OR of slave ACT (address decoded)

Behaviour:
- Reset values: state IDLE; IBUS_REQ/WE=0; IBUS_A/DO=0; IBUS_BA=0; all ACK/ERR=0; all client DO=0; wait counter 0.
- RST_N asserted mid-transaction aborts it immediately. No ACK is issued, and the client must re-request.
- FSM is IDLE -> BUS -> DONE -> IDLE. Every transition is qualified by EN && CE_R.
- IDLE: sample requests. DMA_REQ has priority over CPU_REQ; the grant is latched for the whole transaction.
- IDLE, alignment check: word with A[0]=1, or long with A[1:0]!=0, produces no bus cycle. Go to DONE with ERR=1 and DO=0.
- IDLE, aligned request: drive IBUS_A={A[31:2],2'b00}, IBUS_WE, IBUS_REQ=1, and lanes/data per size. Go to BUS; wait counter=0.
  - byte: BA=1000>>A[1:0]; DO={4{DI[7:0]}}
  - word: BA=A[1]?0011:1100; DO={2{DI[15:0]}}
  - long: BA=1111; DO=DI
- BUS, at each CE_R:
  - !IBUS_ACT: drop REQ; go to DONE with ERR=1 and DO=0. ACT has precedence over BUSY.
  - ACT && BUSY: increment counter. When counter==WAIT_MAX, drop REQ and go to DONE with ERR=1.
  - ACT && !BUSY: drop REQ. For reads, capture IBUS_DI lane-extracted (byte: IBUS_DI[31-8*A[1:0] -: 8]; word: half selected by A[1]). Go to DONE with ERR=0.
- The slave registers read data on the CE_F between the launching CE_R and the completing CE_R. Minimum read/write latency is 2 CE_R from grant to DONE.
- DONE: the granted client's ACK=1, and ERR/DO are valid. The other client sees ACK=0. Requests are ignored in DONE. The next CE_R returns to IDLE and clears ACK/ERR; DO holds.
- The client must drop REQ before the CE_R that ends DONE, otherwise the request is re-served as a new access.
- Throughput: one transaction per 3 CE_R minimum. A pending CPU request waits while DMA_REQ stays asserted (no starvation protection, by design).
- IBUS_A, IBUS_BA and IBUS_DO stay stable while IBUS_REQ=1. They hold their last value after REQ drops.

Test Plan:
- CPU long write 0x12345678 to FFFFFF40, slave ACT=1, BUSY=0 -> IBUS_BA=1111, IBUS_DO=12345678, REQ high for exactly 1 CE_R period, CPU_ACK=1, ERR=0.
- CPU byte read at FFFFFF43, IBUS_DI=AABBCCDD -> IBUS_A=FFFFFF40, BA=0001, CPU_DO=000000DD; word read at FFFFFF42 -> BA=0011, DO=0000CCDD.
- CPU and DMA request on the same CE_R -> DMA served first (DMA_ACK), CPU granted on the IDLE following DMA's DONE.
- Slave BUSY for 3 CE_R then ready -> DONE on the 4th BUS CE_R. With WAIT_MAX=4 and BUSY stuck high -> ERR=1 after 4 samples, DO=0.
- Read of unmapped FFFFFE00 (ACT=0) -> ERR=1, DO=0. Word access to odd address 0xFFFFFF41 -> ERR=1 and IBUS_REQ never asserted.
- RST_N pulsed while in BUS -> IBUS_REQ=0 and ACK=0 immediately. EN=0 during BUS holds REQ and counter unchanged.
